// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Execute-issue stage for the RV32E ALU. Accepts one decoded
//                instruction at a time, reads operands from a 16-entry
//                register file (x0 reads as zero), drives registered operands
//                to a combinational ALU, captures the result, presents it
//                downstream and writes it back on the result handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_issue_stage #(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   // decoded instruction input
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_imm,
   input  logic [3:0]        in_rd,
   input  logic [3:0]        in_rs1,
   input  logic [3:0]        in_rs2,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [2:0]        in_func3,
   input  logic              in_f7_bit,
   // ALU interface
   output logic [XLEN-1:0]   alu_value1,
   output logic [XLEN-1:0]   alu_value2,
   output logic [2:0]        alu_func_type,
   output logic              alu_f7_bit,
   input  logic [XLEN-1:0]   alu_result,
   // result output
   output logic              res_valid,
   input  logic              res_ready,
   output logic [3:0]        res_rd,
   output logic [XLEN-1:0]   res_data,
   // debug read port
   input  logic [3:0]        dbg_addr,
   output logic [XLEN-1:0]   dbg_data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RESULT = 2'd2
   } state_t;

   localparam logic [2:0] C_FUNC3_ADD = 3'b000;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   regs_q [REG_COUNT];
   logic [XLEN-1:0]   regs_d [REG_COUNT];
   logic [XLEN-1:0]   value1_q, value1_d;
   logic [XLEN-1:0]   value2_q, value2_d;
   logic [2:0]        func_q, func_d;
   logic              f7_q, f7_d;
   logic [3:0]        rd_q, rd_d;
   logic [XLEN-1:0]   data_q, data_d;

   logic [XLEN-1:0]   w_rs1_val;
   logic [XLEN-1:0]   w_rs2_val;

   // Register-file read ports; x0 always reads as zero regardless of storage
   always_comb begin
      w_rs1_val = (in_rs1 == 4'd0) ? '0 : regs_q[in_rs1];
      w_rs2_val = (in_rs2 == 4'd0) ? '0 : regs_q[in_rs2];
      dbg_data  = (dbg_addr == 4'd0) ? '0 : regs_q[dbg_addr];
   end

   // Next-state logic: accept in IDLE, capture ALU result in EXEC, retire in RESULT
   always_comb begin
      state_d  = state_q;
      regs_d   = regs_q;
      value1_d = value1_q;
      value2_d = value2_q;
      func_d   = func_q;
      f7_d     = f7_q;
      rd_d     = rd_q;
      data_d   = data_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d  = EXEC;
               value1_d = w_rs1_val;
               value2_d = in_is_imm ? in_imm : w_rs2_val;
               func_d   = in_func3;
               // ADDI has no subtract form, so the f7 select is meaningless there
               f7_d     = in_f7_bit & ~(in_is_imm & (in_func3 == C_FUNC3_ADD));
               rd_d     = in_rd;
            end
         end
         EXEC: begin
            data_d  = alu_result;
            state_d = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               if (rd_q != 4'd0) begin
                  regs_d[rd_q] = data_q;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand, result and register-file flops with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         value1_q <= '0;
         value2_q <= '0;
         func_q   <= '0;
         f7_q     <= 1'b0;
         rd_q     <= '0;
         data_q   <= '0;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         value1_q <= value1_d;
         value2_q <= value2_d;
         func_q   <= func_d;
         f7_q     <= f7_d;
         rd_q     <= rd_d;
         data_q   <= data_d;
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Output mapping from registered state
   always_comb begin
      in_ready      = (state_q == IDLE);
      res_valid     = (state_q == RESULT);
      alu_value1    = value1_q;
      alu_value2    = value2_q;
      alu_func_type = func_q;
      alu_f7_bit    = f7_q;
      res_rd        = rd_q;
      res_data      = data_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage with an RV32 ALU
//                model and an architectural register-file reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_is_imm, in_f7_bit;
   logic [3:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic [2:0]  in_func3;
   logic [31:0] alu_value1, alu_value2, alu_result;
   logic [2:0]  alu_func_type;
   logic        alu_f7_bit;
   logic        res_valid, res_ready;
   logic [3:0]  res_rd;
   logic [31:0] res_data;
   logic [3:0]  dbg_addr;
   logic [31:0] dbg_data;

   int total = 0;
   int bad   = 0;
   logic [31:0] model [16];

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .REG_COUNT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_imm(in_is_imm),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_func3(in_func3), .in_f7_bit(in_f7_bit),
      .alu_value1(alu_value1), .alu_value2(alu_value2),
      .alu_func_type(alu_func_type), .alu_f7_bit(alu_f7_bit),
      .alu_result(alu_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_rd(res_rd),
      .res_data(res_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // RV32 integer ALU semantics
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return f7 ? a - b : a + b;
         3'b001:  return a << b[4:0];
         3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b011:  return (a < b) ? 32'd1 : 32'd0;
         3'b100:  return a ^ b;
         3'b101:  return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_value1, alu_value2, alu_func_type, alu_f7_bit);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_dbg(input string tag, input logic [3:0] a, input logic [31:0] exp);
      dbg_addr = a;
      #1;
      check(tag, dbg_data, exp);
   endtask

   // Issue one instruction, hold res_ready low for 'holds' RESULT cycles, then retire it
   task automatic issue(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [31:0] imm, input logic is_imm, input logic [2:0] f3,
                        input logic f7, input int holds);
      logic [31:0] a, b, exp;
      logic        f7e;
      a   = model[rs1];
      b   = is_imm ? imm : model[rs2];
      f7e = (is_imm && f3 == 3'b000) ? 1'b0 : f7;
      exp = alu_fn(a, b, f3, f7e);

      @(negedge clk);
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_is_imm = is_imm; in_func3 = f3; in_f7_bit = f7;
      @(posedge clk); #1;
      // scramble inputs: only the accepting edge may matter
      in_valid = 1'b1; in_rd = 4'($urandom); in_rs1 = 4'($urandom); in_rs2 = 4'($urandom);
      in_imm = $urandom; in_is_imm = 1'($urandom); in_func3 = 3'($urandom); in_f7_bit = 1'($urandom);
      @(negedge clk);
      check("exec_value1", alu_value1, a);
      check("exec_value2", alu_value2, b);
      check("exec_func", {29'd0, alu_func_type}, {29'd0, f3});
      check("exec_f7", {31'd0, alu_f7_bit}, {31'd0, f7e});
      check("exec_in_ready", {31'd0, in_ready}, 32'd0);
      check("exec_res_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int h = 0; h <= holds; h++) begin
         @(negedge clk);
         check("res_valid", {31'd0, res_valid}, 32'd1);
         check("res_rd", {28'd0, res_rd}, {28'd0, rd});
         check("res_data", res_data, exp);
         check("res_in_ready", {31'd0, in_ready}, 32'd0);
         check_dbg("rd_not_yet_written", rd, model[rd]);
         if (h < holds) begin
            @(posedge clk); #1;
         end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      if (rd != 4'd0) model[rd] = exp;
      @(negedge clk);
      check("retire_in_ready", {31'd0, in_ready}, 32'd1);
      check("retire_res_valid", {31'd0, res_valid}, 32'd0);
      check_dbg("writeback", rd, model[rd]);
   endtask

   initial begin
      logic [31:0] rimm;
      rst_n = 1'b0; in_valid = 1'b0; in_is_imm = 1'b0; in_rd = '0; in_rs1 = '0;
      in_rs2 = '0; in_imm = '0; in_func3 = '0; in_f7_bit = 1'b0;
      res_ready = 1'b0; dbg_addr = '0;
      for (int i = 0; i < 16; i++) model[i] = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_alu_value1", alu_value1, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) check_dbg("rst_dbg", 4'(i), 32'd0);

      // ADDI x1,x0,5 with f7 set: f7 must be forced to 0
      issue(4'd1, 4'd0, 4'd0, 32'd5, 1'b1, 3'b000, 1'b1, 0);
      // ADDI x2,x0,-8 ; SRAI x3,x2,2
      issue(4'd2, 4'd0, 4'd0, 32'hFFFF_FFF8, 1'b1, 3'b000, 1'b0, 0);
      issue(4'd3, 4'd2, 4'd0, 32'd2, 1'b1, 3'b101, 1'b1, 0);
      check_dbg("srai_x3", 4'd3, 32'hFFFF_FFFE);
      // SUB x4,x1,x2 with 3 stall cycles
      issue(4'd4, 4'd1, 4'd2, 32'd0, 1'b0, 3'b000, 1'b1, 3);
      check_dbg("sub_x4", 4'd4, 32'd13);
      // ADDI x0,x1,7 -> result presented, x0 stays zero
      issue(4'd0, 4'd1, 4'd0, 32'd7, 1'b1, 3'b000, 1'b0, 0);
      check_dbg("x0_zero", 4'd0, 32'd0);
      // ADD x5,x0,x1
      issue(4'd5, 4'd0, 4'd1, 32'd0, 1'b0, 3'b000, 1'b0, 0);
      check_dbg("add_x5", 4'd5, 32'd5);

      // randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         rimm = $urandom;
         rimm = {{20{rimm[11]}}, rimm[11:0]};
         issue(4'($urandom), 4'($urandom), 4'($urandom), rimm, 1'($urandom),
               3'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      // reset while a result is pending
      @(negedge clk);
      in_valid = 1'b1; in_rd = 4'd6; in_rs1 = 4'd1; in_is_imm = 1'b1;
      in_imm = 32'd9; in_func3 = 3'b000; in_f7_bit = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_res_valid", {31'd0, res_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      res_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b0;
      for (int i = 0; i < 16; i++) check_dbg("post_rst_dbg", 4'(i), 32'd0);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage directly upstream of the ALU in the RV32E core.
- Accepts one decoded ALU instruction via a valid/ready handshake and reads operands from its internal 16-entry register file (x0 hardwired to zero).
- Drives registered operands and function select to the combinational ALU, captures the ALU result, and presents it downstream.
- Writes the result back to the register file when the downstream handshake completes.

Parameters:
XLEN, 32, datapath width; must match ALU size.
REG_COUNT, 16, architectural registers (RV32E); register index width is 4.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage can accept an instruction
in_is_imm  input  1  1 = operand2 is in_imm, 0 = operand2 is reg[in_rs2]
in_rd  input  4  destination register
in_rs1  input  4  source register 1
in_rs2  input  4  source register 2 (ignored when in_is_imm=1)
in_imm  input  XLEN  sign-extended immediate
in_func3  input  3  ALU function type
in_f7_bit  input  1  sub/arith-shift select from decode
alu_value1  output  XLEN  registered ALU operand 1
alu_value2  output  XLEN  registered ALU operand 2
alu_func_type  output  3  registered function type
alu_f7_bit  output  1  registered f7 select
alu_result  input  XLEN  combinational ALU result
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
res_rd  output  4  destination of presented result
res_data  output  XLEN  presented result
dbg_addr  input  4  debug register read index
dbg_data  output  XLEN  combinational read of reg[dbg_addr]; 0 when dbg_addr=0

Behaviour:
- Reset is asynchronous and active-low (rst_n); single clock domain (clk).
- While reset is asserted:
  - state = IDLE.
  - All registers x1..x15 = 0.
  - alu_value1, alu_value2, alu_func_type, alu_f7_bit, res_rd, res_data = 0.
  - res_valid = 0; in_ready = 1.
- FSM states: IDLE, EXEC, RESULT. in_ready = (state == IDLE); res_valid = (state == RESULT).
- IDLE: on in_valid & in_ready at edge N, go to EXEC and latch:
  - alu_value1 = reg[in_rs1].
  - alu_value2 = in_is_imm ? in_imm : reg[in_rs2].
  - alu_func_type = in_func3; rd into res_rd.
  - alu_f7_bit = in_f7_bit, except forced to 0 when in_is_imm=1 and in_func3=000 (ADDI has no subtract form).
- EXEC (cycle N+1): ALU operands stable for the whole cycle. At edge N+1, capture alu_result into res_data and go to RESULT. No condition; always one cycle.
- RESULT (from cycle N+2): res_valid=1. res_rd and res_data are held stable until the handshake.
  - On res_valid & res_ready at an edge: write res_data to reg[res_rd] unless res_rd=0, then go to IDLE.
  - res_ready low holds RESULT indefinitely with no register write.
- Latency: input handshake to res_valid = 2 cycles. Minimum initiation interval = 3 cycles.
- Hazards: none by construction. The next instruction is accepted only after writeback, so its reads see the new value.
- x0: reads always return 0; writes to x0 are discarded, but res_valid is still asserted with the computed res_data.
- Operand fields are sampled only on the accepting edge. Changes on in_* outside IDLE have no effect.
- Reset mid-operation (EXEC or RESULT): immediate return to IDLE with all state cleared; the pending result is never written.
- ALU outputs keep their last values in IDLE and RESULT; they are not zeroed between instructions.

Test Plan:
- Reset, then sweep dbg_addr 0..15 -> dbg_data=0 for every index; in_ready=1; res_valid=0.
- ADDI x1,x0,5 (is_imm=1, func3=000, imm=5, in_f7_bit=1) -> in EXEC: alu_value1=0, alu_value2=5, alu_f7_bit=0; next cycle res_valid=1, res_rd=1, res_data=5; with res_ready=1, dbg x1=5 after that edge.
- ADDI x2,x0,-8 then SRAI x3,x2,2 (imm=2, func3=101, f7=1) -> alu_value1=0xFFFFFFF8, res_data=0xFFFFFFFE, x3=0xFFFFFFFE.
- SUB x4,x1,x2 (is_imm=0, func3=000, f7=1) with res_ready held low 3 cycles -> res_valid=1 and res_data=13 stable throughout, in_ready=0, x4 unchanged (0) until the handshake; then x4=13.
- ADDI x0,x1,7 -> res_valid=1 with res_data=12; afterwards dbg x0=0, and a following ADD x5,x0,x1 gives res_data=5.
- Assert rst_n low in RESULT before res_ready -> res_valid drops without waiting for a clock edge; x1..x15 read 0 after release; in_ready=1.
